// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and derived sizes for the register-file write path
package regfile_pkg;

    localparam int SEL_W_DEF    = 5;
    localparam int ZERO_REG_DEF = 31;

    // Number of registers addressable by a select of the given width
    function automatic int num_out(input int sel_w);
        return 1 << sel_w;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: combinational binary-to-one-hot decoder with enable, all-zero when disabled
module onehot_dec #(
    parameter int SEL_W = 5
) (
    input  logic               en,
    input  logic [SEL_W-1:0]   sel,
    output logic [2**SEL_W-1:0] onehot
);

    localparam int N = 2**SEL_W;

    // Shift a single set bit to the selected position; gate the whole vector with en
    always_comb onehot = en ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;

endmodule

// File: rtl/regwrite_decoder_sb.sv
// regwrite_decoder_sb: registered one-hot write enable plus pending-write scoreboard for hazard queries
module regwrite_decoder_sb
    import regfile_pkg::*;
#(
    parameter  int SEL_W    = SEL_W_DEF,
    parameter  bit ZERO_EN  = 1'b1,
    parameter  int ZERO_REG = ZERO_REG_DEF,
    localparam int NUM_OUT  = num_out(SEL_W)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               RegWrite,
    input  logic [SEL_W-1:0]   select,
    input  logic               stall,
    output logic [NUM_OUT-1:0] enabler,
    input  logic               issue_en,
    input  logic [SEL_W-1:0]   issue_sel,
    input  logic [SEL_W-1:0]   rs1_sel,
    input  logic [SEL_W-1:0]   rs2_sel,
    output logic [NUM_OUT-1:0] pending,
    output logic               hazard1,
    output logic               hazard2
);

    logic               wb_hit;
    logic               issue_hit;
    logic [NUM_OUT-1:0] wb_onehot;
    logic [NUM_OUT-1:0] set_vec;

    // The hardwired zero register is masked out of both the write and the issue path
    always_comb begin
        wb_hit    = RegWrite && !(ZERO_EN && select == SEL_W'(ZERO_REG));
        issue_hit = issue_en && !(ZERO_EN && issue_sel == SEL_W'(ZERO_REG));
    end

    onehot_dec #(.SEL_W(SEL_W)) u_wb_dec (
        .en     (wb_hit),
        .sel    (select),
        .onehot (wb_onehot)
    );

    onehot_dec #(.SEL_W(SEL_W)) u_issue_dec (
        .en     (issue_hit),
        .sel    (issue_sel),
        .onehot (set_vec)
    );

    // Enabler register: load decoded writeback target unless stalled, then hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            enabler <= '0;
        else if (!stall)
            enabler <= wb_onehot;
    end

    // Scoreboard: issue sets a bit, the presented write enable clears it, set wins on collision
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pending <= '0;
        else
            pending <= set_vec | (pending & ~enabler);
    end

    // Hazard reads see only registered state, with no same-cycle bypass
    always_comb begin
        hazard1 = pending[rs1_sel];
        hazard2 = pending[rs2_sel];
    end

endmodule

// File: tb/tb_regwrite_decoder_sb.sv
// tb_regwrite_decoder_sb: directed and randomized checks against an index-based behavioural model
module tb_regwrite_decoder_sb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        RegWrite = 1'b0;
    logic [4:0]  select = '0;
    logic        stall = 1'b0;
    logic [31:0] enabler;
    logic        issue_en = 1'b0;
    logic [4:0]  issue_sel = '0;
    logic [4:0]  rs1_sel = '0;
    logic [4:0]  rs2_sel = '0;
    logic [31:0] pending;
    logic        hazard1;
    logic        hazard2;

    logic        s_rw = 1'b0;
    logic [1:0]  s_sel = '0;
    logic [3:0]  s_en;
    logic [3:0]  s_pend;
    logic        s_h1;
    logic        s_h2;

    int checks = 0;
    int failures = 0;

    int m_en = -1;
    bit m_pend[32];

    always #5 clk = ~clk;

    regwrite_decoder_sb dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .select(select), .stall(stall),
        .enabler(enabler), .issue_en(issue_en), .issue_sel(issue_sel),
        .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .pending(pending),
        .hazard1(hazard1), .hazard2(hazard2)
    );

    regwrite_decoder_sb #(.SEL_W(2), .ZERO_EN(1'b0), .ZERO_REG(3)) dut2 (
        .clk(clk), .reset(reset), .RegWrite(s_rw), .select(s_sel), .stall(1'b0),
        .enabler(s_en), .issue_en(1'b0), .issue_sel(2'b00),
        .rs1_sel(2'b00), .rs2_sel(2'b00), .pending(s_pend),
        .hazard1(s_h1), .hazard2(s_h2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_en();
        return (m_en < 0) ? 32'h0 : (32'h1 << m_en);
    endfunction

    function automatic logic [31:0] exp_pend();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        m_en = -1;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    endtask

    task automatic drive(input bit rw, input int sel, input bit st, input bit ie, input int isel,
                         input int r1, input int r2);
        RegWrite  = rw;
        select    = 5'(sel);
        stall     = st;
        issue_en  = ie;
        issue_sel = 5'(isel);
        rs1_sel   = 5'(r1);
        rs2_sel   = 5'(r2);
    endtask

    task automatic compare(input string tag);
        check({tag, "/enabler"}, 64'(enabler), 64'(exp_en()));
        check({tag, "/pending"}, 64'(pending), 64'(exp_pend()));
        check({tag, "/hazard1"}, 64'(hazard1), 64'(m_pend[rs1_sel]));
        check({tag, "/hazard2"}, 64'(hazard2), 64'(m_pend[rs2_sel]));
        check({tag, "/onehot"}, 64'($countones(enabler) <= 1), 64'(1));
    endtask

    task automatic step(input string tag);
        int nxt;
        @(posedge clk);
        if (reset) model_reset();
        else begin
            nxt = stall ? m_en : ((RegWrite && select != 5'd31) ? int'(select) : -1);
            for (int i = 0; i < 32; i++)
                if (issue_en && int'(issue_sel) == i && i != 31) m_pend[i] = 1'b1;
                else if (m_en == i) m_pend[i] = 1'b0;
            m_en = nxt;
        end
        @(negedge clk);
        compare(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        compare("reset");
        check("reset_en_const", 64'(enabler), 64'h0);
        reset = 1'b0;

        drive(1, 5, 0, 0, 0, 0, 0);
        step("wb5");
        check("wb5_const", 64'(enabler), 64'h20);
        drive(0, 5, 0, 0, 0, 0, 0);
        step("wb_off");

        drive(1, 31, 0, 0, 0, 31, 31);
        step("wb_zero");
        check("wb_zero_const", 64'(enabler), 64'h0);
        drive(0, 0, 0, 1, 31, 31, 31);
        step("issue_zero");
        check("issue_zero_haz", 64'(hazard1), 64'h0);

        drive(1, 7, 0, 0, 0, 0, 0);
        step("pre_stall");
        for (int k = 0; k < 3; k++) begin
            drive(1, 9, 1, 0, 0, 0, 0);
            step("stall");
            check("stall_const", 64'(enabler), 64'h80);
        end
        drive(1, 9, 0, 0, 0, 0, 0);
        step("unstall");
        check("unstall_const", 64'(enabler), 64'h200);

        drive(0, 0, 0, 1, 3, 0, 3);
        step("issue3");
        check("issue3_haz", 64'(hazard2), 64'h1);
        drive(1, 3, 0, 0, 0, 3, 3);
        step("commit3");
        check("commit3_pend", 64'(pending[3]), 64'h1);
        drive(0, 0, 0, 0, 0, 3, 3);
        step("cleared3");
        check("cleared3_pend", 64'(pending[3]), 64'h0);

        drive(1, 4, 0, 0, 0, 4, 4);
        step("wb4");
        drive(0, 0, 0, 1, 4, 4, 4);
        step("collide4");
        check("collide4_pend", 64'(pending[4]), 64'h1);

        for (int k = 0; k < 500; k++) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 31), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31));
            step("rand");
        end

        drive(0, 0, 0, 0, 0, 0, 0);
        step("drain");
        step("drain2");
        for (int k = 0; k < 32; k++) m_pend[k] = m_pend[k];
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        reset = 1'b0;
        drive(0, 0, 0, 1, 3, 3, 4);
        step("ar_a");
        drive(1, 3, 0, 1, 4, 3, 4);
        step("ar_b");
        check("ar_pend_const", 64'(pending), 64'h18);
        check("ar_en_const", 64'(enabler), 64'h08);
        drive(1, 3, 1, 0, 0, 3, 4);
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare("ar_async");
        check("ar_async_pend", 64'(pending), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        for (int c = 0; c < 8; c++) begin
            s_rw  = c[2];
            s_sel = 2'(c);
            @(posedge clk);
            @(negedge clk);
            check("sel2_dec", 64'(s_en), c[2] ? 64'(1 << (c % 4)) : 64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regwrite_decoder_sb.md
Name: regwrite_decoder_sb

Overview:
Parametrised successor to the gate-level write-enable decoder. Decodes a SEL_W-bit destination register number into a registered one-hot write-enable vector for the register file. Masks the hardwired zero register. Adds a pending-write scoreboard, so the pipeline hazard logic can ask whether a source register has an in-flight write. Sits between the MEM/WB pipeline register and the register file, with scoreboard inputs driven from the decode stage.

Parameters:
SEL_W, 5, width of the register select; NUM_OUT = 2**SEL_W is a derived localparam, not overridable.
ZERO_EN, 1, when 1, register index ZERO_REG is never enabled and never marked pending.
ZERO_REG, 31, index of the hardwired zero register; legal range 0..NUM_OUT-1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high; clears all state immediately.
RegWrite  input  1  writeback write request.
select  input  SEL_W  writeback destination register.
stall  input  1  freezes the enabler register (hold current value).
enabler  output  NUM_OUT  registered one-hot write enable to the register file.
issue_en  input  1  decode stage issues an instruction that writes a register.
issue_sel  input  SEL_W  destination of the issuing instruction.
rs1_sel  input  SEL_W  source-1 register queried for a hazard.
rs2_sel  input  SEL_W  source-2 register queried for a hazard.
pending  output  NUM_OUT  scoreboard state: one bit per register with an outstanding write.
hazard1  output  1  pending[rs1_sel]; combinational read of registered state.
hazard2  output  1  pending[rs2_sel]; combinational read of registered state.

Behaviour:
- Reset (async assert, at any time, including mid-stall): enabler = 0, pending = 0, so hazard1 = hazard2 = 0. The first update is on the first rising edge after deassertion.
- wb_hit = RegWrite && !(ZERO_EN && select == ZERO_REG).
- Enabler stage, latency 1 cycle:
  - stall = 0: enabler <= wb_hit ? (1 << select) : 0.
  - stall = 1: enabler holds its value; RegWrite and select are ignored that cycle.
- Enabler is always one-hot or all-zero; popcount > 1 is a bug.
- Scoreboard, per bit i, each edge:
  - set_i = issue_en && issue_sel == i && !(ZERO_EN && i == ZERO_REG).
  - clr_i = enabler[i], i.e. the registered value currently presented to the register file, so a commit clears its bit.
  - pending[i] <= set_i ? 1 : (clr_i ? 0 : pending[i]).
- Simultaneous set and clear on the same index: set wins. A new write is issued while an older one commits, so the register stays pending.
- Stall with enabler held: the same bit is cleared repeatedly (idempotent). Issue still sets bits during stall; the decode stage gates issue_en itself.
- Zero register: issue and query are legal. pending[ZERO_REG] stays 0 when ZERO_EN = 1, so hazard on the zero register is always 0.
- Hazard outputs: hazard1/hazard2 have no bypass of same-cycle set or clear; they reflect pending as of the last edge.
- Select width: widths are exact and every select value 0..NUM_OUT-1 is in range; no saturation or wrap logic is needed.

Decomposition:
- Shared package regfile_pkg: SEL_W default (5), ZERO_REG default (31), NUM_OUT as a derived localparam function.
- Sub-module onehot_dec (parametrised by SEL_W), combinational: inputs en and sel, output one-hot of width 2**SEL_W, all-zero when en = 0.
  - Instantiated twice: once for the writeback path (en = wb_hit), once for the issue path.
  - Supersedes the fixed 2:4 gate-level decoder; SEL_W = 2 must reproduce its truth table.
- Top level holds the enabler register, the scoreboard register, the zero masks and the hazard muxes.

Test Plan:
- Reset then RegWrite=1, select=5, stall=0 -> enabler=0 in cycle 0; enabler=32'h0000_0020 after one edge; RegWrite=0 next cycle -> enabler=0.
- RegWrite=1, select=31, ZERO_EN=1 -> enabler stays 0. issue_en=1, issue_sel=31 -> pending[31]=0, hazard1=0 with rs1_sel=31.
- Stall hold: enabler=bit 7, then stall=1 with RegWrite=1, select=9 for 3 cycles -> enabler stays 32'h80. stall=0 -> bit 9 after one edge.
- Scoreboard lifecycle: issue_en=1, issue_sel=3 -> pending[3]=1 and hazard2=1 (rs2_sel=3). Later RegWrite=1, select=3 -> enabler[3]=1 next edge, pending[3]=0 the edge after.
- Set/clear collision: while enabler[4]=1, issue_en=1 with issue_sel=4 -> pending[4] remains 1.
- Async reset mid-operation: pending=0x0000_0018 and enabler=bit 3; assert reset between clock edges -> both are 0 immediately, before the next edge. SEL_W=2 instance -> all 8 (RegWrite, select) combinations give a one-hot/zero enabler one cycle later.
